// File: rtl/collision_manager_if.sv
// Collision manager bus: game inputs from the VGA/sprite side, status back to the game.
interface collision_manager_if;
    logic [3:0] state;
    logic [9:0] x;
    logic [9:0] y;
    logic       playerSpriteOn;
    logic [2:0] bulletSpriteOn;
    logic [2:0] collision;
    logic [7:0] hp;
    logic       invulnerable;
    logic       playerBlink;
    logic       gameOver;

    // The collision manager itself is the slave side.
    modport slave (
        input  state, x, y, playerSpriteOn, bulletSpriteOn,
        output collision, hp, invulnerable, playerBlink, gameOver
    );

    // The driver side (game logic / bench).
    modport master (
        output state, x, y, playerSpriteOn, bulletSpriteOn,
        input  collision, hp, invulnerable, playerBlink, gameOver
    );
endinterface

// File: rtl/collision_manager.sv
// Player/bullet collision manager: registers bullet hits on the heart sprite, tracks HP,
// runs a frame-counted invulnerability window and flags game over.
module collision_manager #(
    parameter int unsigned MAX_HP     = 20,
    parameter int unsigned DAMAGE     = 4,
    parameter int unsigned INV_FRAMES = 30
) (
    input  logic                clk,
    input  logic                reset,
    collision_manager_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StActive, StDead} fsm_e;

    fsm_e       fsm_q;
    logic [2:0] col_q, col_d;
    logic [7:0] hp_q, hp_d;
    logic [5:0] cnt_q, cnt_d;
    logic       inv_q;
    logic       blink_q;
    logic       go_q;

    logic       in_battle;
    logic       frame_end;
    logic       hit_en;
    logic [2:0] hits;
    logic [1:0] n_hits;
    logic [9:0] dmg;
    logic [9:0] hp_ext;
    logic       hit_kill;

    // Hit detection, damage and invulnerability counter next-state.
    always_comb begin
        in_battle = (bus.state == 4'd1);
        frame_end = (bus.x == 10'd639) && (bus.y == 10'd479);
        hit_en    = (fsm_q == StActive) && in_battle && bus.playerSpriteOn && !inv_q;
        hits      = hit_en ? (bus.bulletSpriteOn & ~col_q) : 3'b000;
        n_hits    = {1'b0, hits[0]} + {1'b0, hits[1]} + {1'b0, hits[2]};
        // Widened to 10 bits so three hits cannot wrap past zero.
        dmg       = 10'(n_hits) * 10'(DAMAGE);
        hp_ext    = {2'b00, hp_q};
        hp_d      = (dmg >= hp_ext) ? 8'd0 : 8'(hp_ext - dmg);
        col_d     = col_q | hits;
        hit_kill  = (hits != 3'b000) && (hp_d == 8'd0);

        cnt_d = cnt_q;
        if (hits != 3'b000) begin
            cnt_d = 6'(INV_FRAMES);  // a load beats a coincident frame-end decrement
        end else if (frame_end && (cnt_q != 6'd0)) begin
            cnt_d = cnt_q - 6'd1;
        end
    end

    // Round FSM plus all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= StIdle;
            col_q   <= 3'b000;
            hp_q    <= 8'(MAX_HP);
            cnt_q   <= 6'd0;
            inv_q   <= 1'b0;
            blink_q <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            inv_q   <= (cnt_d != 6'd0);
            blink_q <= (cnt_d != 6'd0) && cnt_d[2];
            hp_q    <= hp_d;
            go_q    <= go_q | hit_kill;
            case (fsm_q)
                StIdle: begin
                    if (in_battle) begin
                        fsm_q <= StActive;
                        col_q <= 3'b000;  // new round
                    end
                end
                StActive: begin
                    col_q <= col_d;
                    if (hit_kill) begin
                        fsm_q <= StDead;
                    end else if (!in_battle) begin
                        fsm_q <= StIdle;
                    end
                end
                StDead: begin
                    // Terminal until reset; hits are already masked by hit_en.
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    assign bus.collision    = col_q;
    assign bus.hp           = hp_q;
    assign bus.invulnerable = inv_q;
    assign bus.playerBlink  = blink_q;
    assign bus.gameOver     = go_q;

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: expected outputs are queued as each step is driven
// and compared once the clock edge has produced the DUT response.
module tb_collision_manager;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   failures;

    collision_manager_if ifa ();
    collision_manager_if ifb ();

    collision_manager dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    collision_manager #(
        .MAX_HP     (6),
        .DAMAGE     (4),
        .INV_FRAMES (30)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        bit         dut_b;
        logic [2:0] col;
        logic [7:0] hp;
        logic       inv;
        logic       blink;
        logic       go;
    } exp_t;

    exp_t sb[$];

    function automatic logic blink_of(input int c);
        return (c != 0) && (((c >> 2) & 1) == 1);
    endfunction

    task automatic cmp(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input logic [3:0] st, input logic ps, input logic [2:0] bs, input bit fe);
        ifa.state          = st;
        ifb.state          = st;
        ifa.playerSpriteOn = ps;
        ifb.playerSpriteOn = ps;
        ifa.bulletSpriteOn = bs;
        ifb.bulletSpriteOn = bs;
        ifa.x              = fe ? 10'd639 : 10'd100;
        ifb.x              = fe ? 10'd639 : 10'd100;
        ifa.y              = fe ? 10'd479 : 10'd200;
        ifb.y              = fe ? 10'd479 : 10'd200;
        @(posedge clk);
        #1;
    endtask

    task automatic check_sb();
        exp_t       e;
        logic [2:0] oc;
        logic [7:0] oh;
        logic       oi, ob, og;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.dut_b) begin
                oc = ifb.collision; oh = ifb.hp; oi = ifb.invulnerable;
                ob = ifb.playerBlink; og = ifb.gameOver;
            end else begin
                oc = ifa.collision; oh = ifa.hp; oi = ifa.invulnerable;
                ob = ifa.playerBlink; og = ifa.gameOver;
            end
            cmp({e.tag, ".collision"}, 10'(oc), 10'(e.col));
            cmp({e.tag, ".hp"}, 10'(oh), 10'(e.hp));
            cmp({e.tag, ".invulnerable"}, 10'(oi), 10'(e.inv));
            cmp({e.tag, ".blink"}, 10'(ob), 10'(e.blink));
            cmp({e.tag, ".gameOver"}, 10'(og), 10'(e.go));
        end
    endtask

    // Drive one cycle, queue what the selected DUT must show after the edge, then compare.
    task automatic step(input string tag, input bit on_b, input logic [3:0] st, input logic ps,
                        input logic [2:0] bs, input bit fe, input logic [2:0] col,
                        input logic [7:0] hp, input logic inv, input logic blink,
                        input logic go);
        exp_t e;
        e.tag = tag; e.dut_b = on_b; e.col = col; e.hp = hp;
        e.inv = inv; e.blink = blink; e.go = go;
        sb.push_back(e);
        cyc(st, ps, bs, fe);
        check_sb();
    endtask

    initial begin
        int c;
        checks   = 0;
        failures = 0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        cyc(4'd0, 1'b0, 3'b000, 1'b0);
        step("reset_a", 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        step("reset_b", 1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 3'b000, 8'd6, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;

        // Enter battle, then a single bullet-0 hit.
        step("to_active", 1'b0, 4'd1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        step("single_hit", 1'b0, 4'd1, 1'b1, 3'b001, 1'b0, 3'b001, 8'd16, 1'b1, 1'b1, 1'b0);

        // Overlaps during the window are ignored for 29 frame ends.
        for (int k = 1; k <= 29; k++) begin
            c = 30 - k;
            step($sformatf("inv_ignore%0d", k), 1'b0, 4'd1, 1'b1, 3'b100, 1'b1,
                 3'b001, 8'd16, 1'b1, blink_of(c), 1'b0);
        end
        step("inv_expire", 1'b0, 4'd1, 1'b0, 3'b000, 1'b1, 3'b001, 8'd16, 1'b0, 1'b0, 1'b0);

        // Hit coincident with frame end: the load wins, counter is 30.
        step("hit_at_fe", 1'b0, 4'd1, 1'b1, 3'b100, 1'b1, 3'b101, 8'd12, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            c = 30 - k;
            step($sformatf("decay%0d", k), 1'b0, 4'd1, 1'b0, 3'b000, 1'b1,
                 3'b101, 8'd12, (c != 0), blink_of(c), 1'b0);
        end
        step("hit_b1", 1'b0, 4'd1, 1'b1, 3'b010, 1'b0, 3'b111, 8'd8, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            c = 30 - k;
            step($sformatf("decay2_%0d", k), 1'b0, 4'd1, 1'b0, 3'b000, 1'b1,
                 3'b111, 8'd8, (c != 0), blink_of(c), 1'b0);
        end

        // Round restart clears collision bits, HP untouched.
        step("to_idle", 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 3'b111, 8'd8, 1'b0, 1'b0, 1'b0);
        step("restart", 1'b0, 4'd1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd8, 1'b0, 1'b0, 1'b0);

        // Overlap in the cycle state leaves battle, and in the IDLE->ACTIVE cycle: ignored.
        step("leave_ovl", 1'b0, 4'd0, 1'b1, 3'b111, 1'b0, 3'b000, 8'd8, 1'b0, 1'b0, 1'b0);
        step("idle_ovl", 1'b0, 4'd1, 1'b1, 3'b111, 1'b0, 3'b000, 8'd8, 1'b0, 1'b0, 1'b0);

        // Double hit takes HP exactly to zero.
        step("double_hit", 1'b0, 4'd1, 1'b1, 3'b110, 1'b0, 3'b110, 8'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            c = 30 - k;
            step($sformatf("dead_decay%0d", k), 1'b0, 4'd1, 1'b0, 3'b000, 1'b1,
                 3'b110, 8'd0, (c != 0), blink_of(c), 1'b1);
        end
        step("dead_ovl", 1'b0, 4'd1, 1'b1, 3'b001, 1'b0, 3'b110, 8'd0, 1'b0, 1'b0, 1'b1);
        step("dead_idle", 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 3'b110, 8'd0, 1'b0, 1'b0, 1'b1);
        step("dead_ovl2", 1'b0, 4'd1, 1'b1, 3'b001, 1'b0, 3'b110, 8'd0, 1'b0, 1'b0, 1'b1);

        // Saturation on the MAX_HP=6 instance: triple hit floors HP at zero.
        rst_b = 1'b0;
        step("b_idle", 1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 3'b000, 8'd6, 1'b0, 1'b0, 1'b0);
        step("b_active", 1'b1, 4'd1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd6, 1'b0, 1'b0, 1'b0);
        step("b_triple", 1'b1, 4'd1, 1'b1, 3'b111, 1'b0, 3'b111, 8'd0, 1'b1, 1'b1, 1'b1);
        step("b_dead_idle", 1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 3'b111, 8'd0, 1'b1, 1'b1, 1'b1);
        step("b_dead_ovl", 1'b1, 4'd1, 1'b1, 3'b111, 1'b0, 3'b111, 8'd0, 1'b1, 1'b1, 1'b1);

        // Reset out of DEAD, then reset in the middle of a window.
        rst_a = 1'b1;
        step("reset_dead", 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        step("r_active", 1'b0, 4'd1, 1'b0, 3'b000, 1'b0, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        step("r_hit", 1'b0, 4'd1, 1'b1, 3'b001, 1'b0, 3'b001, 8'd16, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            c = 30 - k;
            step($sformatf("r_decay%0d", k), 1'b0, 4'd1, 1'b0, 3'b000, 1'b1,
                 3'b001, 8'd16, 1'b1, blink_of(c), 1'b0);
        end
        rst_a = 1'b1;
        step("reset_mid", 1'b0, 4'd1, 1'b1, 3'b010, 1'b1, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        rst_a = 1'b0;
        step("post_rst_act", 1'b0, 4'd1, 1'b1, 3'b010, 1'b0, 3'b000, 8'd20, 1'b0, 1'b0, 1'b0);
        step("post_rst_hit", 1'b0, 4'd1, 1'b1, 3'b010, 1'b0, 3'b010, 8'd16, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
